ahbl_slave_decoder: RTL and testbench

AHBL_SLAVE_DECODER -- requirements
Module: ahbl_slave_decoder

---
 rtl/ahbl_slave_decoder.sv | 81 ++++++++
 tb/tb_ahbl_slave_decoder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_slave_decoder.sv
// AHB-Lite address decoder and response multiplexer. Decodes 16 regions from the top address nibble.
// Routes the selected slave's data-phase response back to the master. Unmapped accesses go to an external default slave.
`timescale 1ns/1ps
module ahbl_slave_decoder #(
    parameter logic [15:0] SLAVE_EN = 16'hFFFF,
    parameter int          ADDR_MSB = 31
) (
    input  logic         HCLK,
    input  logic         aresetn,
    input  logic [31:0]  HADDR,
    input  logic [1:0]   HTRANS,
    input  logic [15:0]  HREADYOUT_S,
    input  logic [15:0]  HRESP_S,
    input  logic [511:0] HRDATA_S,
    input  logic         DEFSLAVEDATAREADY,
    input  logic         HRESP_DEFAULT,
    output logic [15:0]  HSEL_S,
    output logic         DEFSLAVEDATASEL,
    output logic         HREADY,
    output logic         HRESP,
    output logic [31:0]  HRDATA,
    output logic [7:0]   ERR_COUNT
);

    logic        w_active;
    logic [3:0]  w_idx;
    logic        w_mapped;
    logic        w_unmapped;
    logic        w_unusedAddr;

    logic [15:0] r_dataSel;
    logic        r_defPending;
    logic [7:0]  r_errCount;

    // IDLE and BUSY never select anything; only NONSEQ/SEQ open a data phase.
    assign w_active     = HTRANS[1];
    assign w_idx        = HADDR[ADDR_MSB -: 4];
    assign w_mapped     = SLAVE_EN[w_idx];
    assign w_unmapped   = w_active && !w_mapped;
    assign w_unusedAddr = ^HADDR;

    assign HSEL_S          = (w_active && w_mapped) ? (16'h0001 << w_idx) : 16'h0000;
    assign DEFSLAVEDATASEL = r_defPending;
    assign ERR_COUNT       = r_errCount;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0000_0000;
        if (r_defPending) begin
            HREADY = DEFSLAVEDATAREADY;
            HRESP  = HRESP_DEFAULT;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_dataSel[i]) begin
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                    HRDATA = HRDATA_S[32*i +: 32];
                end
            end
        end
    end

    // The address phase only advances into the data phase when the current transfer completes.
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            r_dataSel    <= 16'h0000;
            r_defPending <= 1'b0;
            r_errCount   <= 8'h00;
        end else begin
            if (HREADY) begin
                r_dataSel    <= HSEL_S;
                r_defPending <= w_unmapped;
            end
            if (r_defPending && !HREADY && (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_slave_decoder.sv
// Self-checking bench for ahbl_slave_decoder with a two-cycle default slave attached.
// A transaction-level model tracks the current data-phase target and the error count.
`timescale 1ns/1ps
module tb_ahbl_slave_decoder;

    localparam logic [15:0] EN = 16'h0003;

    logic         HCLK = 1'b0;
    logic         aresetn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [15:0]  HREADYOUT_S;
    logic [15:0]  HRESP_S;
    logic [511:0] HRDATA_S;
    logic         DEFSLAVEDATAREADY;
    logic         HRESP_DEFAULT;
    logic [15:0]  HSEL_S;
    logic         DEFSLAVEDATASEL;
    logic         HREADY;
    logic         HRESP;
    logic [31:0]  HRDATA;
    logic [7:0]   ERR_COUNT;

    int nTests = 0;
    int nFail  = 0;

    // Model state: mTgt is -1 for no data phase, 0..15 for a slave, 16 for the default slave.
    int mTgt  = -1;
    int mErr  = 0;
    bit mCyc2 = 1'b0;

    logic defCyc2;

    ahbl_slave_decoder #(.SLAVE_EN(EN), .ADDR_MSB(31)) dut (
        .HCLK(HCLK), .aresetn(aresetn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .DEFSLAVEDATAREADY(DEFSLAVEDATAREADY), .HRESP_DEFAULT(HRESP_DEFAULT),
        .HSEL_S(HSEL_S), .DEFSLAVEDATASEL(DEFSLAVEDATASEL), .HREADY(HREADY),
        .HRESP(HRESP), .HRDATA(HRDATA), .ERR_COUNT(ERR_COUNT)
    );

    always #5 HCLK = ~HCLK;

    // Attached default slave: ERROR with one wait state, then ERROR with ready.
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) defCyc2 <= 1'b0;
        else          defCyc2 <= DEFSLAVEDATASEL && !defCyc2;
    end
    assign DEFSLAVEDATAREADY = !DEFSLAVEDATASEL || defCyc2;
    assign HRESP_DEFAULT     = DEFSLAVEDATASEL;

    function automatic int decode(logic [31:0] a, logic [1:0] t);
        logic [3:0] idx;
        idx = a[31:28];
        if (!t[1]) return -1;
        return EN[idx] ? int'(idx) : 16;
    endfunction

    function automatic logic [15:0] expSel();
        int d;
        d = decode(HADDR, HTRANS);
        return (d >= 0 && d < 16) ? (16'h0001 << d) : 16'h0000;
    endfunction

    function automatic logic expReady();
        if (mTgt < 0) return 1'b1;
        if (mTgt == 16) return mCyc2;
        return HREADYOUT_S[mTgt];
    endfunction

    function automatic logic expResp();
        if (mTgt < 0) return 1'b0;
        if (mTgt == 16) return 1'b1;
        return HRESP_S[mTgt];
    endfunction

    function automatic logic [31:0] expData();
        if (mTgt >= 0 && mTgt < 16) return HRDATA_S[32*mTgt +: 32];
        return 32'h0;
    endfunction

    // Advance the model across one rising edge, then step the bench to 1ns after that edge.
    task automatic advance();
        logic r;
        r = expReady();
        if (mTgt == 16 && !r) begin
            if (mErr < 255) mErr++;
            mCyc2 = 1'b1;
        end else begin
            mCyc2 = 1'b0;
        end
        if (r) mTgt = decode(HADDR, HTRANS);
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HTRANS  = 2'b00;
        aresetn = 1'b0;
        mTgt = -1; mErr = 0; mCyc2 = 1'b0;
        @(negedge HCLK);
        aresetn = 1'b1;
        advance();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        HADDR = 32'h1000_0000; HTRANS = 2'b10;
        HREADYOUT_S = 16'hFFFF; HRESP_S = 16'h0000;
        for (int j = 0; j < 16; j++) HRDATA_S[32*j +: 32] = $urandom;
        #3;
        nTests++;
        if ({DEFSLAVEDATASEL, HREADY, HRESP, HRDATA, ERR_COUNT} !== {1'b0, 1'b1, 1'b0, 32'h0, 8'h0}) begin
            nFail++;
            $display("[TB] FAIL reset_outputs: got %h want %h",
                     {DEFSLAVEDATASEL, HREADY, HRESP, HRDATA, ERR_COUNT}, {1'b0, 1'b1, 1'b0, 32'h0, 8'h0});
        end
        nTests++;
        if (HSEL_S !== 16'h0002) begin
            nFail++;
            $display("[TB] FAIL reset_hsel_comb: got %h want %h", HSEL_S, 16'h0002);
        end
        HADDR = 32'h5000_0000;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        nTests++;
        if ({DEFSLAVEDATASEL, HREADY, HRESP} !== 3'b010) begin
            nFail++;
            $display("[TB] FAIL reset_held_clocked: got %b want %b", {DEFSLAVEDATASEL, HREADY, HRESP}, 3'b010);
        end
        do_reset();
    endtask

    task automatic test_mapped_read();
        HADDR = 32'h1000_0000; HTRANS = 2'b10;
        HREADYOUT_S = 16'hFFFF; HRESP_S = 16'h0000;
        HRDATA_S[63:32] = 32'hA5A5_1234;
        #2;
        nTests++;
        if (HSEL_S !== 16'h0002) begin
            nFail++;
            $display("[TB] FAIL mapped_hsel: got %h want %h", HSEL_S, 16'h0002);
        end
        advance();
        HTRANS = 2'b00;
        #2;
        nTests++;
        if ({HRDATA, HREADY, HRESP} !== {32'hA5A5_1234, 1'b1, 1'b0}) begin
            nFail++;
            $display("[TB] FAIL mapped_data: got %h want %h", {HRDATA, HREADY, HRESP}, {32'hA5A5_1234, 1'b1, 1'b0});
        end
        advance();
    endtask

    task automatic test_unmapped_error();
        HADDR = 32'h5000_0000; HTRANS = 2'b10;
        #2;
        nTests++;
        if (HSEL_S !== 16'h0000) begin
            nFail++;
            $display("[TB] FAIL unmapped_hsel: got %h want %h", HSEL_S, 16'h0000);
        end
        advance();
        HTRANS = 2'b00;
        #2;
        nTests++;
        if ({DEFSLAVEDATASEL, HREADY, HRESP} !== 3'b101) begin
            nFail++;
            $display("[TB] FAIL error_cycle1: got %b want %b", {DEFSLAVEDATASEL, HREADY, HRESP}, 3'b101);
        end
        advance();
        #2;
        nTests++;
        if ({DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT} !== {3'b111, 8'd1}) begin
            nFail++;
            $display("[TB] FAIL error_cycle2: got %h want %h", {DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT}, {3'b111, 8'd1});
        end
        advance();
        #2;
        nTests++;
        if ({DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT} !== {3'b010, 8'd1}) begin
            nFail++;
            $display("[TB] FAIL error_idle_clears: got %h want %h", {DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT}, {3'b010, 8'd1});
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] w0;
        w0 = $urandom;
        HRDATA_S[31:0] = w0;
        HADDR = 32'h0000_0000; HTRANS = 2'b10; HREADYOUT_S = 16'hFFFF;
        #2;
        advance();
        for (int k = 0; k < 3; k++) begin
            HREADYOUT_S[0] = 1'b0;
            HADDR = {4'h1, 28'($urandom)};
            #2;
            nTests++;
            if ({HREADY, HRDATA, HSEL_S} !== {1'b0, w0, 16'h0002}) begin
                nFail++;
                $display("[TB] FAIL wait_state_%0d: got %h want %h", k, {HREADY, HRDATA, HSEL_S}, {1'b0, w0, 16'h0002});
            end
            advance();
        end
        HREADYOUT_S[0] = 1'b1;
        #2;
        nTests++;
        if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, w0}) begin
            nFail++;
            $display("[TB] FAIL wait_complete: got %h want %h", {HREADY, HRESP, HRDATA}, {1'b1, 1'b0, w0});
        end
        advance();
        HTRANS = 2'b00;
        #2;
        nTests++;
        if (HRDATA !== HRDATA_S[63:32]) begin
            nFail++;
            $display("[TB] FAIL wait_next_phase: got %h want %h", HRDATA, HRDATA_S[63:32]);
        end
        advance();
    endtask

    task automatic test_busy();
        HADDR = 32'h1000_0000; HTRANS = 2'b01;
        #2;
        nTests++;
        if (HSEL_S !== 16'h0000) begin
            nFail++;
            $display("[TB] FAIL busy_hsel: got %h want %h", HSEL_S, 16'h0000);
        end
        advance();
        HTRANS = 2'b00;
        #2;
        nTests++;
        if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            nFail++;
            $display("[TB] FAIL busy_response: got %h want %h", {HREADY, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        end
        advance();
    endtask

    task automatic test_random();
        logic [58:0] got, want;
        logic [3:0]  idx;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       idx = 4'd0;
                1:       idx = 4'd1;
                default: idx = 4'($urandom_range(0, 15));
            endcase
            HADDR       = {idx, 28'($urandom)};
            HTRANS      = 2'($urandom);
            HREADYOUT_S = ~(16'($urandom) & 16'($urandom));
            HRESP_S     = 16'($urandom);
            for (int j = 0; j < 16; j++) HRDATA_S[32*j +: 32] = $urandom;
            #2;
            got  = {HSEL_S, DEFSLAVEDATASEL, HREADY, HRESP, HRDATA, ERR_COUNT};
            want = {expSel(), (mTgt == 16), expReady(), expResp(), expData(), 8'(mErr)};
            nTests++;
            if (got !== want) begin
                nFail++;
                $display("[TB] FAIL random_cycle_%0d: got %h want %h", n, got, want);
            end
            advance();
        end
        HRESP_S = 16'h0000; HREADYOUT_S = 16'hFFFF; HTRANS = 2'b00;
        while (!expReady()) advance();
        advance();
    endtask

    task automatic test_back_to_back();
        do_reset();
        HREADYOUT_S = 16'hFFFF;
        HADDR = 32'h5000_0000; HTRANS = 2'b10;
        advance();
        for (int k = 0; k < 257; k++) begin
            #2;
            nTests++;
            if ({DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT} !== {3'b101, 8'(mErr)}) begin
                nFail++;
                $display("[TB] FAIL b2b_cycle1_%0d: got %h want %h", k, {DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT}, {3'b101, 8'(mErr)});
            end
            advance();
            if (k == 256) HTRANS = 2'b00;
            else          HADDR = {4'($urandom_range(2, 15)), 28'($urandom)};
            #2;
            nTests++;
            if ({DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT} !== {3'b111, 8'(mErr)}) begin
                nFail++;
                $display("[TB] FAIL b2b_cycle2_%0d: got %h want %h", k, {DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT}, {3'b111, 8'(mErr)});
            end
            advance();
        end
        #2;
        nTests++;
        if ({DEFSLAVEDATASEL, ERR_COUNT} !== {1'b0, 8'd255}) begin
            nFail++;
            $display("[TB] FAIL b2b_saturate: got %h want %h", {DEFSLAVEDATASEL, ERR_COUNT}, {1'b0, 8'd255});
        end
    endtask

    task automatic test_reset_mid_error();
        HADDR = 32'h7000_0000; HTRANS = 2'b10;
        #2;
        advance();
        HTRANS = 2'b10;
        HADDR  = 32'h9000_0000;
        #2;
        nTests++;
        if ({HREADY, HRESP, ERR_COUNT} !== {2'b01, 8'(mErr)}) begin
            nFail++;
            $display("[TB] FAIL mid_error_before: got %h want %h", {HREADY, HRESP, ERR_COUNT}, {2'b01, 8'(mErr)});
        end
        aresetn = 1'b0;
        mTgt = -1; mErr = 0; mCyc2 = 1'b0;
        #1;
        nTests++;
        if ({DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT} !== {3'b010, 8'd0}) begin
            nFail++;
            $display("[TB] FAIL mid_error_async_reset: got %h want %h", {DEFSLAVEDATASEL, HREADY, HRESP, ERR_COUNT}, {3'b010, 8'd0});
        end
        HTRANS = 2'b00;
        @(negedge HCLK);
        aresetn = 1'b1;
        advance();
        HADDR = 32'h1000_0000; HTRANS = 2'b10;
        #2;
        nTests++;
        if (HSEL_S !== 16'h0002) begin
            nFail++;
            $display("[TB] FAIL post_reset_hsel: got %h want %h", HSEL_S, 16'h0002);
        end
        advance();
        HTRANS = 2'b00;
        #2;
        nTests++;
        if ({DEFSLAVEDATASEL, HREADY, HRESP, HRDATA} !== {1'b0, 1'b1, 1'b0, expData()}) begin
            nFail++;
            $display("[TB] FAIL post_reset_read: got %h want %h", {DEFSLAVEDATASEL, HREADY, HRESP, HRDATA}, {1'b0, 1'b1, 1'b0, expData()});
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_mapped_read();
        test_unmapped_error();
        test_wait_states();
        test_busy();
        test_random();
        test_back_to_back();
        test_reset_mid_error();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
